// File: rtl/cam_ctrl_pkg.sv
// Shared encodings for the CAM request manager: op codes, response status codes and FSM states.
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP   = 2'd0,
    OP_INSERT   = 2'd1,
    OP_DELETE   = 2'd2,
    OP_RESERVED = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    STAT_HIT       = 3'd0,
    STAT_INSERTED  = 3'd1,
    STAT_NOT_FOUND = 3'd2,
    STAT_FULL      = 3'd3,
    STAT_BAD_OP    = 3'd4
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CAM = 3'd1,
    ST_READ     = 3'd2,
    ST_DECIDE   = 3'd3,
    ST_ISSUE    = 3'd4,
    ST_WAIT_WR  = 3'd5,
    ST_RESP     = 3'd6
  } state_e;

endpackage

// File: rtl/cam_ctrl_if.sv
// Request/response channels between table-management logic and cam_ctrl.
// Both channels are valid/ready: a beat transfers on a clock edge where valid and ready are both 1;
// the sender holds valid and its payload stable until that edge, and ready may depend on nothing the
// sender drives in the same cycle.
interface cam_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [DATA_WIDTH-1:0] req_key;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [2:0]            resp_status;
  logic [ADDR_WIDTH-1:0] resp_addr;

  modport master (
    output req_valid, req_op, req_key, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_addr
  );

  modport slave (
    input  req_valid, req_op, req_key, resp_ready,
    output req_ready, resp_valid, resp_status, resp_addr
  );
endinterface

// File: rtl/cam_ctrl_pe.sv
// Priority encoder: index of the lowest set bit of req, plus a flag saying any bit was set.
module cam_ctrl_pe #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cam_ctrl.sv
// Request-side manager for a BRAM CAM: handles LOOKUP/INSERT/DELETE by key, allocates slots
// from an occupancy bitmap and sequences the CAM write port. One request in flight at a time.
module cam_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  cam_ctrl_if.slave             bus,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output state_e                dbg_state
);
  localparam int N = 2 ** ADDR_WIDTH;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  status_e               status_q, status_d;
  logic                  del_q, del_d;
  logic [N-1:0]          bitmap_q, bitmap_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  logic [ADDR_WIDTH-1:0] free_addr;
  logic                  free_found;

  cam_ctrl_pe #(.WIDTH(N), .IDX_W(ADDR_WIDTH)) u_free_pe (
    .req   (~bitmap_q),
    .idx   (free_addr),
    .found (free_found)
  );

  assign full             = ~free_found;
  assign occupancy        = occ_q;
  assign bus.req_ready    = (state_q == ST_IDLE) && !rst;
  assign bus.resp_valid   = (state_q == ST_RESP);
  assign bus.resp_status  = status_q;
  assign bus.resp_addr    = addr_q;
  assign cam_write_enable = (state_q == ST_ISSUE);
  // addr/key/delete registers stay untouched from DECIDE to RESP, so the CAM sees a stable write port.
  assign cam_write_addr   = addr_q;
  assign cam_write_data   = key_q;
  assign cam_write_delete = del_q;
  assign cam_compare_data = key_q;
  assign dbg_state        = state_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    addr_d   = addr_q;
    status_d = status_q;
    del_d    = del_q;
    bitmap_d = bitmap_q;
    occ_d    = occ_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          op_d    = op_e'(bus.req_op);
          key_d   = bus.req_key;
          state_d = ST_WAIT_CAM;
        end
      end
      ST_WAIT_CAM: if (!cam_write_busy) state_d = ST_READ;
      ST_READ:     state_d = ST_DECIDE;
      ST_DECIDE: begin
        addr_d  = '0;
        del_d   = 1'b0;
        state_d = ST_RESP;
        case (op_q)
          OP_LOOKUP: begin
            status_d = cam_match ? STAT_HIT : STAT_NOT_FOUND;
            addr_d   = cam_match ? cam_match_addr : '0;
          end
          OP_INSERT: begin
            if (cam_match) begin
              status_d = STAT_HIT;
              addr_d   = cam_match_addr;
            end else if (full) begin
              status_d = STAT_FULL;
            end else begin
              status_d = STAT_INSERTED;
              addr_d   = free_addr;
              state_d  = ST_ISSUE;
            end
          end
          OP_DELETE: begin
            if (cam_match) begin
              status_d = STAT_HIT;
              addr_d   = cam_match_addr;
              del_d    = 1'b1;
              state_d  = ST_ISSUE;
            end else begin
              status_d = STAT_NOT_FOUND;
            end
          end
          default: status_d = STAT_BAD_OP;
        endcase
      end
      ST_ISSUE: begin
        // Guard on the bitmap bit so occupancy can never wrap.
        if (del_q && bitmap_q[addr_q]) begin
          bitmap_d[addr_q] = 1'b0;
          occ_d            = occ_q - (ADDR_WIDTH + 1)'(1);
        end else if (!del_q && !bitmap_q[addr_q]) begin
          bitmap_d[addr_q] = 1'b1;
          occ_d            = occ_q + (ADDR_WIDTH + 1)'(1);
        end
        state_d = ST_WAIT_WR;
      end
      ST_WAIT_WR: if (!cam_write_busy) state_d = ST_RESP;
      ST_RESP:    if (bus.resp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOOKUP;
      key_q    <= '0;
      addr_q   <= '0;
      status_q <= STAT_HIT;
      del_q    <= 1'b0;
      bitmap_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      addr_q   <= addr_d;
      status_q <= status_d;
      del_q    <= del_d;
      bitmap_q <= bitmap_d;
      occ_q    <= occ_d;
    end
  end
endmodule
